// File: rtl/memctrl_pkg.sv
// Shared types and helpers for the byte-serial memory bus arbiter.
// Holds state encodings, the IO region default, LEN_W sizing and byte-lane extraction.
package memctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   localparam logic [1:0] IO_ADDR_HI_DEF = 2'b11;

   // Widest store word byte_lane() accepts; callers zero-extend to this.
   localparam int MAX_BYTES = 16;
   localparam int LANE_W    = 8 * MAX_BYTES;

   function automatic int len_w(input int bytes);
      return $clog2(bytes) + 1;
   endfunction

   function automatic logic [7:0] byte_lane(input logic [LANE_W-1:0] d,
                                            input int unsigned k);
      return d[8*k +: 8];
   endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Request vector to one-hot grant, fixed priority or round-robin.
// Ports: clk, rst (async, high), i_en (grant taken), i_req, o_gnt (one-hot).
module mem_rr_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ARB_MODE  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic [NUM_PORTS-1:0] i_req,
   output logic [NUM_PORTS-1:0] o_gnt
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_base;
   logic [PTR_W-1:0] w_idx;
   logic [PTR_W-1:0] w_cand;
   logic             w_found;

   // r_ptr names the first port searched: the one after the last grant.
   always_comb begin
      w_base  = (ARB_MODE != 0) ? r_ptr : '0;
      o_gnt   = '0;
      w_idx   = '0;
      w_cand  = '0;
      w_found = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_cand = PTR_W'((int'(w_base) + i) % NUM_PORTS);
         if (!w_found && i_req[w_cand]) begin
            w_found       = 1'b1;
            w_idx         = w_cand;
            o_gnt[w_cand] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_en && w_found) begin
         r_ptr <= (w_idx == PTR_W'(NUM_PORTS - 1)) ? '0
                  : w_idx + PTR_W'(1);
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates NUM_PORTS requesters onto the shared 8-bit RAM/IO bus.
// Ports: clk, rst, rdy, flush, mem_din/mem_dout/mem_a/mem_wr, io_buffer_full,
// req_valid/we/addr/len/wdata in, req_done/rdata/busy out.
// Optional MEMCTRL_LOAD_EXT_EN adds req_sext for sign-extended loads.
module mem_bus_arbiter
   import memctrl_pkg::*;
#(
   parameter int                   NUM_PORTS  = 2,
   parameter int                   ADDR_W     = 32,
   parameter int                   DATA_BYTES = 4,
   parameter int                   ARB_MODE   = 1,
   parameter logic [NUM_PORTS-1:0] FLUSH_MASK = 'b01,
   parameter logic [1:0]           IO_ADDR_HI = IO_ADDR_HI_DEF,
   localparam int                  DATA_W     = 8 * DATA_BYTES,
   localparam int                  LEN_W      = len_w(DATA_BYTES)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rdy,
   input  logic                          flush,
   input  logic [7:0]                    mem_din,
   output logic [7:0]                    mem_dout,
   output logic [ADDR_W-1:0]             mem_a,
   output logic                          mem_wr,
   input  logic                          io_buffer_full,
   input  logic [NUM_PORTS-1:0]          req_valid,
   input  logic [NUM_PORTS-1:0]          req_we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
   input  logic [NUM_PORTS*LEN_W-1:0]    req_len,
   input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
`ifdef MEMCTRL_LOAD_EXT_EN
   input  logic [NUM_PORTS-1:0]          req_sext,
`endif
   output logic [NUM_PORTS-1:0]          req_done,
   output logic [DATA_W-1:0]             rdata,
   output logic                          busy
);

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_BYTES);

   state_e                r_state, n_state;
   logic [ADDR_W-1:0]     r_a, n_a;
   logic                  r_wr, n_wr;
   logic [7:0]            r_dout, n_dout;
   logic [NUM_PORTS-1:0]  r_done, n_done;
   logic [DATA_W-1:0]     r_rdata, n_rdata;
   logic [LEN_W-1:0]      r_cnt, n_cnt;
   logic [LEN_W-1:0]      r_len, n_len;
   logic [DATA_W-1:0]     r_wdata, n_wdata;
   logic [NUM_PORTS-1:0]  r_port, n_port;
   logic [DATA_W-1:0]     r_buf, n_buf;
`ifdef MEMCTRL_LOAD_EXT_EN
   logic                  r_sext, n_sext;
`endif

   logic [NUM_PORTS-1:0]  w_req;
   logic [NUM_PORTS-1:0]  w_gnt;
   logic [ADDR_W-1:0]     w_sel_addr;
   logic [LEN_W-1:0]      w_sel_raw;
   logic [LEN_W-1:0]      w_sel_len;
   logic [DATA_W-1:0]     w_sel_wdata;
   logic                  w_sel_we;
   logic                  w_sel_sext;
   logic [DATA_W-1:0]     w_rd;

   function automatic logic is_io(input logic [ADDR_W-1:0] a);
      return a[17:16] == IO_ADDR_HI;
   endfunction

   assign w_req = req_valid & ~(flush ? FLUSH_MASK : '0);

   mem_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .ARB_MODE  (ARB_MODE)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_en  (rdy),
      .i_req ((r_state == ST_IDLE) ? w_req : '0),
      .o_gnt (w_gnt)
   );

   always_comb begin
      w_sel_addr  = '0;
      w_sel_raw   = '0;
      w_sel_wdata = '0;
      w_sel_we    = 1'b0;
      w_sel_sext  = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_gnt[p]) begin
            w_sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
            w_sel_raw   = req_len[p*LEN_W +: LEN_W];
            w_sel_wdata = req_wdata[p*DATA_W +: DATA_W];
            w_sel_we    = req_we[p];
`ifdef MEMCTRL_LOAD_EXT_EN
            w_sel_sext  = req_sext[p];
`endif
         end
      end
      w_sel_len = (w_sel_raw == '0 || w_sel_raw > LEN_MAX) ? LEN_MAX
                  : w_sel_raw;
   end

   always_comb begin
      n_state = r_state;
      n_a     = r_a;
      n_wr    = r_wr;
      n_dout  = r_dout;
      n_done  = '0;
      n_rdata = r_rdata;
      n_cnt   = r_cnt;
      n_len   = r_len;
      n_wdata = r_wdata;
      n_port  = r_port;
      n_buf   = r_buf;
`ifdef MEMCTRL_LOAD_EXT_EN
      n_sext  = r_sext;
`endif
      w_rd    = r_buf;
      unique case (r_state)
         ST_IDLE: begin
            n_a  = '0;
            n_wr = 1'b0;
            if (|w_gnt) begin
               n_port  = w_gnt;
               n_a     = w_sel_addr;
               n_len   = w_sel_len;
               n_wdata = w_sel_wdata;
               n_cnt   = '0;
               n_buf   = '0;
`ifdef MEMCTRL_LOAD_EXT_EN
               n_sext  = w_sel_sext;
`endif
               if (w_sel_we) begin
                  n_state = ST_WRITE;
                  n_dout  = byte_lane(LANE_W'(w_sel_wdata), 0);
                  // A full UART holds off even the first byte.
                  n_wr    = !(is_io(w_sel_addr) && io_buffer_full);
               end else begin
                  n_state = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (flush && |(r_port & FLUSH_MASK)) begin
               n_state = ST_IDLE;
               n_a     = '0;
            end else begin
               w_rd[{r_cnt, 3'b000} +: 8] = mem_din;
               n_buf = w_rd;
               if (r_cnt == r_len - LEN_W'(1)) begin
`ifdef MEMCTRL_LOAD_EXT_EN
                  if (r_sext) begin
                     for (int b = 0; b < DATA_BYTES; b++) begin
                        if (b > int'(r_cnt)) begin
                           w_rd[8*b +: 8] = {8{mem_din[7]}};
                        end
                     end
                  end
`endif
                  n_rdata = w_rd;
                  n_done  = r_port;
                  n_state = ST_IDLE;
                  n_a     = '0;
               end else begin
                  n_cnt = r_cnt + LEN_W'(1);
                  n_a   = r_a + ADDR_W'(1);
               end
            end
         end
         ST_WRITE: begin
            // r_wr low means the current byte is still waiting on the UART.
            if (r_wr) begin
               if (r_cnt == r_len - LEN_W'(1)) begin
                  n_wr    = 1'b0;
                  n_done  = r_port;
                  n_state = ST_IDLE;
                  n_a     = '0;
               end else begin
                  n_cnt  = r_cnt + LEN_W'(1);
                  n_a    = r_a + ADDR_W'(1);
                  n_dout = byte_lane(LANE_W'(r_wdata), int'(r_cnt) + 1);
                  n_wr   = !(is_io(r_a + ADDR_W'(1)) && io_buffer_full);
               end
            end else begin
               n_wr = !(is_io(r_a) && io_buffer_full);
            end
         end
         default: n_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_wr    <= 1'b0;
         r_dout  <= '0;
         r_done  <= '0;
         r_rdata <= '0;
         r_cnt   <= '0;
         r_len   <= '0;
         r_wdata <= '0;
         r_port  <= '0;
         r_buf   <= '0;
`ifdef MEMCTRL_LOAD_EXT_EN
         r_sext  <= 1'b0;
`endif
      end else if (rdy) begin
         r_state <= n_state;
         r_a     <= n_a;
         r_wr    <= n_wr;
         r_dout  <= n_dout;
         r_done  <= n_done;
         r_rdata <= n_rdata;
         r_cnt   <= n_cnt;
         r_len   <= n_len;
         r_wdata <= n_wdata;
         r_port  <= n_port;
         r_buf   <= n_buf;
`ifdef MEMCTRL_LOAD_EXT_EN
         r_sext  <= n_sext;
`endif
      end
   end

   assign mem_a    = r_a;
   assign mem_wr   = r_wr;
   assign mem_dout = r_dout;
   assign req_done = r_done;
   assign rdata    = r_rdata;
   assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter against a byte-array memory.
// A second instance in fixed-priority mode shares all inputs.
module tb_mem_bus_arbiter;

`ifdef MEMCTRL_LOAD_EXT_EN
   localparam bit SEXT = 1'b1;
`else
   localparam bit SEXT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, rdy, flush, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [1:0]  req_valid, req_we, req_done, req_sext;
   logic [63:0] req_addr, req_wdata;
   logic [5:0]  req_len;
   logic [31:0] rdata;
   logic        busy;

   logic [7:0]  fx_dout;
   logic [31:0] fx_a;
   logic        fx_wr;
   logic [1:0]  fx_done;
   logic [31:0] fx_rdata;
   logic        fx_busy;

   logic [7:0]  ram [0:4095];
   int          io_cnt;
   logic [7:0]  io_last;

   int checks = 0;
   int errors = 0;
   int last_gnt = 1;

   always #5 clk = ~clk;

   mem_bus_arbiter dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
      .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_len(req_len), .req_wdata(req_wdata),
`ifdef MEMCTRL_LOAD_EXT_EN
      .req_sext(req_sext),
`endif
      .req_done(req_done), .rdata(rdata), .busy(busy)
   );

   mem_bus_arbiter #(.ARB_MODE(0)) dut_fx (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .mem_din(mem_din), .mem_dout(fx_dout), .mem_a(fx_a),
      .mem_wr(fx_wr), .io_buffer_full(io_buffer_full),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_len(req_len), .req_wdata(req_wdata),
`ifdef MEMCTRL_LOAD_EXT_EN
      .req_sext(req_sext),
`endif
      .req_done(fx_done), .rdata(fx_rdata), .busy(fx_busy)
   );

   assign mem_din = (mem_a[17:16] == 2'b11) ? 8'h00 : ram[mem_a[11:0]];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) ram[i] <= 8'(i * 37 + 5);
         ram[12'h100] <= 8'h11;
         ram[12'h101] <= 8'h22;
         ram[12'h102] <= 8'h33;
         ram[12'h103] <= 8'h44;
         ram[12'h180] <= 8'h80;
         io_cnt  <= 0;
         io_last <= 8'h00;
      end else if (mem_wr) begin
         if (mem_a[17:16] == 2'b11) begin
            io_cnt  <= io_cnt + 1;
            io_last <= mem_dout;
         end else begin
            ram[mem_a[11:0]] <= mem_dout;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request on port p; fl_n/hold_n/full_n pick flush, rdy-low and
   // UART-full episodes by cycle number after the drive.
   task automatic access(input int p, input bit we, input logic [31:0] addr,
                         input int len, input logic [31:0] wd, input bit sx,
                         input int fl_n, input int hold_n, input int full_n,
                         input bit exp_done);
      int          nb, exp_n, io_before;
      logic [31:0] exp_rd, rd_before, a_hold, got_w, exp_w;
      bit          got;
      nb = (len == 0 || len > 4) ? 4 : len;
      exp_rd = '0;
      for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = ram[12'(addr + k)];
      if (SEXT && sx && exp_rd[8*(nb-1)+7])
         for (int k = nb; k < 4; k++) exp_rd[8*k +: 8] = 8'hFF;
      exp_n = nb + 1 + full_n + ((hold_n > 0) ? 4 : 0);
      rd_before = rdata;
      io_before = io_cnt;
      a_hold = '0;
      got = 1'b0;
      @(negedge clk);
      chk("idle_before", {63'd0, busy}, 64'd0);
      req_valid = '0;
      req_valid[p] = 1'b1;
      req_we[p] = we;
      req_addr[p*32 +: 32] = addr;
      req_len[p*3 +: 3] = len[2:0];
      req_wdata[p*32 +: 32] = wd;
      req_sext[p] = sx;
      io_buffer_full = (full_n > 0);
      last_gnt = p;
      for (int n = 1; n <= 30 && !got; n++) begin
         @(negedge clk);
         if (full_n > 0 && n <= full_n)
            chk("io_stall_wr", {63'd0, mem_wr}, 64'd0);
         if (full_n > 0 && n == full_n) io_buffer_full = 1'b0;
         if (full_n > 0 && n == full_n + 1) begin
            chk("io_wr", {63'd0, mem_wr}, 64'd1);
            chk("io_dout", {56'd0, mem_dout}, {56'd0, wd[7:0]});
         end
         if (hold_n == 0 && full_n == 0 && n <= nb &&
             (fl_n == 0 || we || n <= fl_n)) begin
            chk("mem_a_seq", {32'd0, mem_a}, {32'd0, addr + n - 1});
            if (we) begin
               chk("wr_seq", {63'd0, mem_wr}, 64'd1);
               chk("dout_seq", {56'd0, mem_dout}, {56'd0, wd[8*(n-1) +: 8]});
            end
         end
         if (fl_n > 0 && n == fl_n) begin
            flush = 1'b1;
            if (!exp_done) req_valid = '0;
         end
         if (fl_n > 0 && n == fl_n + 1) begin
            flush = 1'b0;
            if (!exp_done) begin
               chk("abort_idle", {63'd0, busy}, 64'd0);
               chk("abort_a", {32'd0, mem_a}, 64'd0);
            end
         end
         if (hold_n > 0 && n == hold_n) begin
            rdy = 1'b0;
            a_hold = mem_a;
         end
         if (hold_n > 0 && n == hold_n + 4) begin
            chk("hold_a", {32'd0, mem_a}, {32'd0, a_hold});
            rdy = 1'b1;
         end
         if (req_done != 2'b00) begin
            got = 1'b1;
            req_valid = '0;
            chk("done_port", {62'd0, req_done}, 64'd1 << p);
            chk("latency", 64'(n), 64'(exp_n));
            chk("done_a", {32'd0, mem_a}, 64'd0);
            chk("done_wr", {63'd0, mem_wr}, 64'd0);
            if (!we) chk("rdata", {32'd0, rdata}, {32'd0, exp_rd});
         end
      end
      req_valid = '0;
      flush = 1'b0;
      rdy = 1'b1;
      io_buffer_full = 1'b0;
      chk("done_seen", {63'd0, got}, {63'd0, exp_done});
      if (!exp_done) chk("rdata_kept", {32'd0, rdata}, {32'd0, rd_before});
      if (we && addr[17:16] == 2'b11) begin
         chk("io_count", 64'(io_cnt - io_before), 64'(nb));
         chk("io_byte", {56'd0, io_last}, {56'd0, wd[8*(nb-1) +: 8]});
      end else if (we) begin
         got_w = '0;
         exp_w = '0;
         for (int k = 0; k < nb; k++) begin
            got_w[8*k +: 8] = ram[12'(addr + k)];
            exp_w[8*k +: 8] = wd[8*k +: 8];
         end
         chk("ram_written", {32'd0, got_w}, {32'd0, exp_w});
      end
   endtask

   initial begin
      int got;
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
      req_wdata = '0; req_sext = '0;
      repeat (3) @(negedge clk);
      chk("rst_a", {32'd0, mem_a}, 64'd0);
      chk("rst_wr", {63'd0, mem_wr}, 64'd0);
      chk("rst_dout", {56'd0, mem_dout}, 64'd0);
      chk("rst_done", {62'd0, req_done}, 64'd0);
      chk("rst_rdata", {32'd0, rdata}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      rst = 1'b0;

      access(0, 0, 32'h100, 4, 0, 0, 0, 0, 0, 1);
      access(1, 1, 32'h30000, 1, 32'hAB, 0, 0, 0, 3, 1);
      access(0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 1);
      access(1, 0, 32'h101, 7, 0, 0, 0, 0, 0, 1);
      access(0, 0, 32'h100, 4, 0, 0, 3, 0, 0, 0);
      access(1, 1, 32'h300, 2, 32'h0000_5AC3, 0, 1, 0, 0, 1);
      access(0, 1, 32'h320, 2, 32'h0000_9D17, 0, 1, 0, 0, 1);
      access(0, 0, 32'h100, 4, 0, 0, 0, 2, 0, 1);
      access(0, 0, 32'h180, 1, 0, 1, 0, 0, 0, 1);
      access(1, 0, 32'h180, 1, 0, 0, 0, 0, 0, 1);
      access(0, 1, 32'h400, 3, 32'h00C0_FFEE, 0, 0, 0, 0, 1);

      @(negedge clk);
      req_we = 2'b00;
      req_addr = {32'h104, 32'h100};
      req_len = {3'd1, 3'd1};
      req_valid = 2'b11;
      got = 0;
      for (int n = 0; n < 40 && got < 4; n++) begin
         @(negedge clk);
         if (fx_done != 2'b00)
            chk("fixed_prio", {62'd0, fx_done}, 64'd1);
         if (req_done != 2'b00) begin
            last_gnt = (last_gnt + 1) % 2;
            chk("rr_order", {62'd0, req_done}, 64'd1 << last_gnt);
            got++;
         end
      end
      req_valid = 2'b00;
      chk("rr_count", 64'(got), 64'd4);

      for (int t = 0; t < 16; t++) begin
         int          p, ln;
         bit          w, s;
         logic [31:0] a, d;
         p  = $urandom_range(0, 1);
         w  = 1'($urandom_range(0, 1));
         a  = $urandom_range(32'h200, 32'hEF0);
         ln = $urandom_range(0, 7);
         d  = $urandom;
         s  = 1'($urandom_range(0, 1));
         access(p, w, a, ln, d, s, 0, 0, 0, 1);
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
